// File: rtl/memory_stage_pkg.sv
// Shared opcode/funct3 encodings for the memory stage and its alignment unit.
// Also provides the address-alignment / reserved-encoding fault check.
// Pure declarations; no state.
package memory_stage_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // 1 when a load/store has a misaligned address or a reserved funct3; 0 for non-memory ops
  function automatic logic mem_fault(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [1:0] a);
    logic f;
    f = 1'b0;
    if (op == OP_LOAD) begin
      case (f3)
        F3_LB, F3_LBU: f = 1'b0;
        F3_LH, F3_LHU: f = a[0];
        F3_LW:         f = |a;
        default:       f = 1'b1;
      endcase
    end else if (op == OP_STORE) begin
      case (f3)
        F3_SB:   f = 1'b0;
        F3_SH:   f = a[0];
        F3_SW:   f = |a;
        default: f = 1'b1;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/memory_stage_align.sv
// Byte-lane steering for stores and extract/extend for loads.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module mem_align_unit
  import memory_stage_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_st_data,
  input  logic [31:0] i_ld_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_ld_shift;

  // Move the addressed byte/half down to bit 0 before extension
  assign w_ld_shift = i_ld_word >> {i_addr_lo, 3'b000};

  // Store: replicate data across lanes, enable only the addressed lanes
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = i_st_data;
    case (i_funct3)
      F3_SB: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_st_data[7:0]}};
      end
      F3_SH: begin
        o_be    = 4'b0011 << i_addr_lo;
        o_wdata = {2{i_st_data[15:0]}};
      end
      F3_SW:   o_be = 4'hF;
      default: o_be = 4'b0000;
    endcase
  end

  // Load: sign- or zero-extend the selected byte/half, whole word as-is
  always_comb begin
    o_ld_data = 32'd0;
    case (i_funct3)
      F3_LB:   o_ld_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
      F3_LH:   o_ld_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
      F3_LW:   o_ld_data = i_ld_word;
      F3_LBU:  o_ld_data = {24'd0, w_ld_shift[7:0]};
      F3_LHU:  o_ld_data = {16'd0, w_ld_shift[15:0]};
      default: o_ld_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: registers execute results, runs data-memory loads/stores on req/gnt/rvalid.
// Latency: non-memory 1 cycle; store >= 2 cycles; load >= 3 cycles (bounded by WAIT_MAX rvalid timeout).
// Backpressure: m_allow_in drops while an access is outstanding or writeback refuses a finished result.
module memory_stage #(
  parameter int WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        e_to_m_valid,
  output logic        m_allow_in,
  output logic        m_to_w_valid,
  input  logic        w_allow_in,
  output logic        m_valid,
  input  logic [2:0]  E_instr_type,
  input  logic [6:0]  E_opcode,
  input  logic [9:0]  E_funct,
  input  logic [4:0]  E_rd,
  input  logic [31:0] e_valE,
  input  logic [31:0] E_val2,
  input  logic [31:0] E_default_pc,
  input  logic [31:0] E_cur_pc,
  input  logic [31:0] E_instr,
  input  logic        E_commit,
  input  logic [31:0] E_pred_pc,
  output logic [2:0]  M_instr_type,
  output logic [6:0]  M_opcode,
  output logic [9:0]  M_funct,
  output logic [4:0]  M_rd,
  output logic [31:0] M_valE,
  output logic [31:0] M_val2,
  output logic [31:0] M_default_pc,
  output logic [31:0] M_cur_pc,
  output logic [31:0] M_instr,
  output logic        M_commit,
  output logic [31:0] M_pred_pc,
  output logic [31:0] m_valM,
  output logic        m_misalign,
  output logic        m_bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);
  import memory_stage_pkg::*;

  localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_valid;
  logic [CW-1:0] r_cnt;
  logic          w_fire, w_is_load, w_is_store, w_is_mem, w_pending, w_ready_go;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_ld_data;

  assign w_is_load  = (M_opcode == OP_LOAD);
  assign w_is_store = (M_opcode == OP_STORE);
  assign w_is_mem   = w_is_load | w_is_store;
  // A freshly captured, well-formed access issues its request straight from IDLE
  assign w_pending  = r_valid & w_is_mem & ~m_misalign & (r_state == S_IDLE);
  assign w_ready_go = ~(r_valid & w_is_mem & ~m_misalign) | (r_state == S_DONE);

  assign m_valid      = r_valid;
  assign m_allow_in   = ~r_valid | (w_ready_go & w_allow_in);
  assign m_to_w_valid = r_valid & w_ready_go;
  assign w_fire       = m_allow_in & e_to_m_valid;

  assign dmem_req   = w_pending | (r_state == S_REQ);
  assign dmem_we    = dmem_req & w_is_store;
  assign dmem_be    = dmem_we ? w_be : 4'b0000;
  assign dmem_addr  = {M_valE[31:2], 2'b00};
  assign dmem_wdata = w_wdata;

  mem_align_unit u_align (
    .i_funct3  (M_funct[2:0]),
    .i_addr_lo (M_valE[1:0]),
    .i_st_data (M_val2),
    .i_ld_word (dmem_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_ld_data (w_ld_data)
  );

  // Capture execute results whenever this stage accepts a valid instr; hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      M_instr_type <= '0;
      M_opcode     <= '0;
      M_funct      <= '0;
      M_rd         <= '0;
      M_valE       <= '0;
      M_val2       <= '0;
      M_default_pc <= '0;
      M_cur_pc     <= '0;
      M_instr      <= '0;
      M_commit     <= 1'b0;
      M_pred_pc    <= '0;
      m_misalign   <= 1'b0;
    end else begin
      if (m_allow_in) r_valid <= e_to_m_valid;
      if (w_fire) begin
        M_instr_type <= E_instr_type;
        M_opcode     <= E_opcode;
        M_funct      <= E_funct;
        M_rd         <= E_rd;
        M_valE       <= e_valE;
        M_val2       <= E_val2;
        M_default_pc <= E_default_pc;
        M_cur_pc     <= E_cur_pc;
        M_instr      <= E_instr;
        M_commit     <= E_commit;
        M_pred_pc    <= E_pred_pc;
        m_misalign   <= mem_fault(E_opcode, E_funct[2:0], e_valE[1:0]);
      end
    end
  end

  // Bus FSM next state: request until granted, loads then wait for rvalid or time out
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_REQ: begin
        if (r_state == S_REQ || w_pending) begin
          if (dmem_gnt) w_state_nxt = w_is_load ? S_WAIT : S_DONE;
          else          w_state_nxt = S_REQ;
        end
      end
      S_WAIT:  if (dmem_rvalid || r_cnt == CNT_LAST) w_state_nxt = S_DONE;
      S_DONE:  if (w_allow_in) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // WAIT cycle counter, restarted on every entry into WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_cnt <= '0;
    else if (r_state != S_WAIT)  r_cnt <= '0;
    else                         r_cnt <= r_cnt + 1'b1;
  end

  // Load result and timeout flag: cleared on capture, set only from WAIT (stray rvalid ignored)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valM    <= '0;
      m_bus_err <= 1'b0;
    end else if (w_fire) begin
      m_valM    <= '0;
      m_bus_err <= 1'b0;
    end else if (r_state == S_WAIT) begin
      if (dmem_rvalid)              m_valM    <= w_ld_data;
      else if (r_cnt == CNT_LAST)   m_bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_ADD   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        e_to_m_valid, m_allow_in, m_to_w_valid, w_allow_in, m_valid;
  logic [2:0]  E_instr_type, M_instr_type;
  logic [6:0]  E_opcode, M_opcode;
  logic [9:0]  E_funct, M_funct;
  logic [4:0]  E_rd, M_rd;
  logic [31:0] e_valE, E_val2, E_default_pc, E_cur_pc, E_instr, E_pred_pc;
  logic        E_commit, M_commit;
  logic [31:0] M_valE, M_val2, M_default_pc, M_cur_pc, M_instr, M_pred_pc, m_valM;
  logic        m_misalign, m_bus_err;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  memory_stage #(.WAIT_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .e_to_m_valid(e_to_m_valid), .m_allow_in(m_allow_in), .m_to_w_valid(m_to_w_valid),
    .w_allow_in(w_allow_in), .m_valid(m_valid),
    .E_instr_type(E_instr_type), .E_opcode(E_opcode), .E_funct(E_funct), .E_rd(E_rd),
    .e_valE(e_valE), .E_val2(E_val2), .E_default_pc(E_default_pc),
    .E_cur_pc(E_cur_pc), .E_instr(E_instr), .E_commit(E_commit), .E_pred_pc(E_pred_pc),
    .M_instr_type(M_instr_type), .M_opcode(M_opcode), .M_funct(M_funct), .M_rd(M_rd),
    .M_valE(M_valE), .M_val2(M_val2), .M_default_pc(M_default_pc),
    .M_cur_pc(M_cur_pc), .M_instr(M_instr), .M_commit(M_commit), .M_pred_pc(M_pred_pc),
    .m_valM(m_valM), .m_misalign(m_misalign), .m_bus_err(m_bus_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata)
  );

  // Present one instr from execute; captured at the next posedge if the stage accepts
  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] vale, input logic [31:0] val2);
    e_to_m_valid = 1'b1;
    E_opcode     = op;
    E_funct      = {7'd0, f3};
    e_valE       = vale;
    E_val2       = val2;
  endtask

  // Load with immediate grant and rvalid one cycle later; returns result seen in DONE
  task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                          output logic [31:0] valm, output logic vld);
    set_instr(OPC_LOAD, f3, addr, 32'd0);
    dmem_gnt = 1'b1;
    @(negedge clk);
    e_to_m_valid = 1'b0;
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    valm = m_valM;
    vld  = m_to_w_valid;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b want=0", m_valid); end
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", dmem_req); end
    total++; if (dmem_be !== 4'b0000 || dmem_we !== 1'b0) begin bad++; $display("FAIL rst_be_we got=%b/%b want=0000/0", dmem_be, dmem_we); end
    total++; if (M_valE !== 32'd0 || m_valM !== 32'd0) begin bad++; $display("FAIL rst_vals got=%h/%h want=0/0", M_valE, m_valM); end
    total++; if (m_misalign !== 1'b0 || m_bus_err !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b/%b want=0/0", m_misalign, m_bus_err); end
    total++; if (m_allow_in !== 1'b1) begin bad++; $display("FAIL rst_allow got=%b want=1", m_allow_in); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    set_instr(OPC_ADD, 3'b000, 32'h5, 32'h0);
    E_cur_pc = 32'h100; E_default_pc = 32'h104; E_rd = 5'd7; E_commit = 1'b1;
    @(negedge clk);
    e_to_m_valid = 1'b0;
    total++; if (m_to_w_valid !== 1'b1) begin bad++; $display("FAIL add_vld got=%b want=1", m_to_w_valid); end
    total++; if (M_valE !== 32'h5) begin bad++; $display("FAIL add_valE got=%h want=5", M_valE); end
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL add_req got=%b want=0", dmem_req); end
    total++; if (M_default_pc !== 32'h104 || M_cur_pc !== 32'h100 || M_rd !== 5'd7 || M_commit !== 1'b1)
      begin bad++; $display("FAIL add_pass got=%h/%h/%0d/%b want=104/100/7/1", M_default_pc, M_cur_pc, M_rd, M_commit); end
    @(negedge clk);
    total++; if (m_valid !== 1'b0 || M_valE !== 32'h5) begin bad++; $display("FAIL add_retire got=%b/%h want=0/5", m_valid, M_valE); end
  endtask

  task automatic test_load_lb();
    set_instr(OPC_LOAD, 3'b000, 32'h1003, 32'h0);
    dmem_gnt = 1'b1;
    @(negedge clk);
    e_to_m_valid = 1'b0;
    total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_be !== 4'b0000)
      begin bad++; $display("FAIL lb_req got=%b/%b/%b want=1/0/0000", dmem_req, dmem_we, dmem_be); end
    total++; if (dmem_addr !== 32'h1000) begin bad++; $display("FAIL lb_addr got=%h want=00001000", dmem_addr); end
    total++; if (m_allow_in !== 1'b0 || m_to_w_valid !== 1'b0) begin bad++; $display("FAIL lb_stall got=%b/%b want=0/0", m_allow_in, m_to_w_valid); end
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    total++; if (m_to_w_valid !== 1'b0 || dmem_req !== 1'b0) begin bad++; $display("FAIL lb_wait got=%b/%b want=0/0", m_to_w_valid, dmem_req); end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_FF00;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    total++; if (m_to_w_valid !== 1'b1) begin bad++; $display("FAIL lb_vld got=%b want=1", m_to_w_valid); end
    total++; if (m_valM !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_data got=%h want=ffffff80", m_valM); end
    @(negedge clk);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL lb_retire got=%b want=0", m_valid); end
  endtask

  task automatic test_load_half();
    logic [31:0] v;
    logic        ok;
    run_load(3'b001, 32'h6000, 32'h1234_F00D, v, ok);
    total++; if (v !== 32'hFFFF_F00D || ok !== 1'b1) begin bad++; $display("FAIL lh_data got=%h/%b want=fffff00d/1", v, ok); end
    run_load(3'b101, 32'h6002, 32'h8765_4321, v, ok);
    total++; if (v !== 32'h0000_8765 || ok !== 1'b1) begin bad++; $display("FAIL lhu_data got=%h/%b want=00008765/1", v, ok); end
    run_load(3'b010, 32'h6004, 32'hDEAD_BEEF, v, ok);
    total++; if (v !== 32'hDEAD_BEEF || ok !== 1'b1) begin bad++; $display("FAIL lw_data got=%h/%b want=deadbeef/1", v, ok); end
  endtask

  task automatic test_store_sh_hold();
    set_instr(OPC_STORE, 3'b001, 32'h2002, 32'h0000_ABCD);
    dmem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e_to_m_valid = 1'b0;
      total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== 4'b1100 ||
                   dmem_wdata !== 32'hABCD_ABCD || dmem_addr !== 32'h2000)
        begin bad++; $display("FAIL sh_req[%0d] got=%b/%b/%b/%h/%h want=1/1/1100/abcdabcd/00002000",
                              i, dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr); end
    end
    dmem_gnt = 1'b1; w_allow_in = 1'b0;
    @(negedge clk);
    dmem_gnt = 1'b0;
    total++; if (m_to_w_valid !== 1'b1 || m_allow_in !== 1'b0 || dmem_req !== 1'b0)
      begin bad++; $display("FAIL sh_done got=%b/%b/%b want=1/0/0", m_to_w_valid, m_allow_in, dmem_req); end
    set_instr(OPC_ADD, 3'b000, 32'hDEAD, 32'h0);
    @(negedge clk);
    total++; if (M_valE !== 32'h2002 || m_valid !== 1'b1 || m_allow_in !== 1'b0)
      begin bad++; $display("FAIL sh_hold got=%h/%b/%b want=00002002/1/0", M_valE, m_valid, m_allow_in); end
    w_allow_in = 1'b1; e_to_m_valid = 1'b0;
    @(negedge clk);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL sh_retire got=%b want=0", m_valid); end
  endtask

  task automatic test_store_lanes();
    set_instr(OPC_STORE, 3'b000, 32'h4001, 32'h1234_5678);
    dmem_gnt = 1'b1;
    @(negedge clk);
    e_to_m_valid = 1'b0;
    total++; if (dmem_be !== 4'b0010 || dmem_wdata !== 32'h7878_7878)
      begin bad++; $display("FAIL sb_lane got=%b/%h want=0010/78787878", dmem_be, dmem_wdata); end
    @(negedge clk);
    total++; if (m_to_w_valid !== 1'b1) begin bad++; $display("FAIL sb_vld got=%b want=1", m_to_w_valid); end
    set_instr(OPC_STORE, 3'b010, 32'h4004, 32'hCAFE_F00D);
    @(negedge clk);
    e_to_m_valid = 1'b0;
    total++; if (dmem_be !== 4'hF || dmem_wdata !== 32'hCAFE_F00D || dmem_addr !== 32'h4004)
      begin bad++; $display("FAIL sw_lane got=%b/%h/%h want=1111/cafef00d/00004004", dmem_be, dmem_wdata, dmem_addr); end
    @(negedge clk);
    dmem_gnt = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_misalign();
    set_instr(OPC_LOAD, 3'b010, 32'h3001, 32'h0);
    @(negedge clk);
    total++; if (m_misalign !== 1'b1 || dmem_req !== 1'b0) begin bad++; $display("FAIL lw_mis got=%b/%b want=1/0", m_misalign, dmem_req); end
    total++; if (m_to_w_valid !== 1'b1 || m_valM !== 32'd0) begin bad++; $display("FAIL lw_mis_vld got=%b/%h want=1/0", m_to_w_valid, m_valM); end
    set_instr(OPC_LOAD, 3'b011, 32'h3000, 32'h0);
    @(negedge clk);
    total++; if (m_misalign !== 1'b1 || dmem_req !== 1'b0) begin bad++; $display("FAIL ld_rsv got=%b/%b want=1/0", m_misalign, dmem_req); end
    set_instr(OPC_STORE, 3'b001, 32'h2001, 32'h0);
    @(negedge clk);
    total++; if (m_misalign !== 1'b1 || dmem_req !== 1'b0) begin bad++; $display("FAIL sh_mis got=%b/%b want=1/0", m_misalign, dmem_req); end
    set_instr(OPC_ADD, 3'b000, 32'h9, 32'h0);
    @(negedge clk);
    e_to_m_valid = 1'b0;
    total++; if (m_misalign !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b want=0", m_misalign); end
    @(negedge clk);
  endtask

  task automatic test_bus_err();
    set_instr(OPC_LOAD, 3'b010, 32'h5000, 32'h0);
    dmem_gnt = 1'b1;
    @(negedge clk);
    e_to_m_valid = 1'b0;
    total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL be_req got=%b want=1", dmem_req); end
    @(negedge clk);
    dmem_gnt = 1'b0;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      total++; if (m_to_w_valid !== 1'b0) begin bad++; $display("FAIL be_wait[%0d] got=%b want=0", k, m_to_w_valid); end
    end
    @(negedge clk);
    total++; if (m_to_w_valid !== 1'b1 || m_bus_err !== 1'b1 || m_valM !== 32'd0)
      begin bad++; $display("FAIL be_timeout got=%b/%b/%h want=1/1/0", m_to_w_valid, m_bus_err, m_valM); end
    set_instr(OPC_ADD, 3'b000, 32'h1, 32'h0);
    @(negedge clk);
    e_to_m_valid = 1'b0;
    total++; if (m_bus_err !== 1'b0) begin bad++; $display("FAIL be_clear got=%b want=0", m_bus_err); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_req();
    set_instr(OPC_LOAD, 3'b010, 32'h7000, 32'h0);
    dmem_gnt = 1'b0;
    @(negedge clk);
    e_to_m_valid = 1'b0;
    total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL mid_req got=%b want=1", dmem_req); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (dmem_req !== 1'b0 || m_valid !== 1'b0) begin bad++; $display("FAIL mid_async got=%b/%b want=0/0", dmem_req, m_valid); end
    @(negedge clk);
    rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    total++; if (m_valM !== 32'd0 || m_valid !== 1'b0 || dmem_req !== 1'b0 || m_to_w_valid !== 1'b0)
      begin bad++; $display("FAIL mid_after got=%h/%b/%b/%b want=0/0/0/0", m_valM, m_valid, dmem_req, m_to_w_valid); end
  endtask

  initial begin
    rst_n = 1'b0; e_to_m_valid = 1'b0; w_allow_in = 1'b1;
    E_instr_type = 3'd0; E_opcode = 7'd0; E_funct = 10'd0; E_rd = 5'd0;
    e_valE = 32'd0; E_val2 = 32'd0; E_default_pc = 32'd0; E_cur_pc = 32'd0;
    E_instr = 32'd0; E_commit = 1'b0; E_pred_pc = 32'd0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    test_reset();
    test_add();
    test_load_lb();
    test_load_half();
    test_store_sh_hold();
    test_store_lanes();
    test_misalign();
    test_bus_err();
    test_reset_mid_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
